audio_sample_sequencer: RTL and testbench
=========================================

# audio_sample_sequencer

Sequencer that owns the sample handshake of `Audio_Controller` and sits between it and the rest of the audio design. Each cycle of the block moves one stereo sample from the ADC FIFO to the DAC FIFO. On the way it applies a sample-count-based mute gate (chopper effect) and offers a 16-bit copy of the left channel to a downstream consumer over valid/ready, for example the recognizer front-end. It also holds the LED level register, so the top level only wires ports.

## Interface
- `DW`, 32, audio sample width per channel
- `GW`, 17, width of gate period and sample counter
- `CW`, 8, width of saturating capture-drop counter
- `CLOCK_50` in 1, sole clock, all logic rising-edge
- `resetn` in 1, asynchronous active-low reset
- `enable` in 1, level; 0 = stop after current sample, hold handshakes low
- `gate_period` in GW, samples per half-period of gate; 0 = bypass (never mute)
- `audio_in_available` in 1, from Audio_Controller
- `audio_out_allowed` in 1, from Audio_Controller
- `left_in`, `right_in` in DW, ADC samples, valid while `audio_in_available`=1
- `read_audio_in` out 1, one-cycle pop pulse to ADC FIFO
- `write_audio_out` out 1, one-cycle push pulse to DAC FIFO
- `left_out`, `right_out` out DW, registered DAC samples, stable during `write_audio_out`
- `cap_valid` out 1, capture word available
- `cap_ready` in 1, consumer accepts when `cap_valid`&`cap_ready`
- `cap_data` out 16, `left_in[DW-1:DW-16]`, pre-gate
- `drop_cnt` out CW, captures lost because `cap_valid`=1 and `cap_ready`=0; saturates at 2^CW-1
- `level` out 16, `left_out[DW-1:DW-16]` of last written sample (LED drive)

## Operation
- FSM states: IDLE, WAIT, LATCH, XFER, GAP.
- IDLE: handshakes low. Go to WAIT when `enable`=1.
- WAIT: if `enable`=0, go to IDLE. Else if `audio_in_available`&`audio_out_allowed`, go to LATCH.
- LATCH: register `left_in`/`right_in` into the sample regs. Compute `left_out`/`right_out` = sample, or 0 when gate phase=1. Go to XFER unconditionally.
- XFER: `read_audio_in`=`write_audio_out`=1 for exactly this cycle. Advance the gate counter, perform the capture load, update `level`. Go to GAP.
- GAP: one idle cycle so the FIFO flags settle. Go to WAIT if `enable`, else IDLE.
- `enable` falling in LATCH/XFER does not abort the sample; the sequence completes.
- Gate counter, on each XFER:
  - `gate_period`=0: `cnt`←0, `phase`←0.
  - `cnt` ≥ `gate_period`−1: `cnt`←0, `phase`←~`phase`.
  - otherwise: `cnt`←`cnt`+1.
  - The ≥ compare makes a reduced `gate_period` take effect without a 2^GW wrap.
- Capture, on XFER:
  - If `cap_valid`=0, or `cap_valid`&`cap_ready` this cycle: load `cap_data`, `cap_valid`←1.
  - Otherwise: keep the old word, `drop_cnt`←min(`drop_cnt`+1, max).
  - Outside XFER: `cap_valid`&`cap_ready` clears `cap_valid`.
- All outputs are registered. Reset values: state IDLE; all outputs 0; `cnt`=0, `phase`=0.

## Timing
- Latency: flags high in WAIT at cycle n → LATCH at n+1 → handshake pulses at n+2 → GAP at n+3 → earliest next WAIT at n+4. Minimum 4 cycles per sample (≪ 1042 cycles at 48 kHz).
- Output data is valid from cycle n+2 (XFER) and held until the next LATCH.
- `cap_data`/`cap_valid` change at the end of XFER. A handshake at cap_valid&ready frees the slot in the same cycle.
- Async reset mid-operation: pulses drop immediately. At most one sample is lost, with no half-pop, because read and write pulses are always simultaneous.
- `gate_period` and `enable` are sampled synchronously. The switch source is the top level's responsibility.

## Structure
- Package `audio_seq_pkg`: state encoding constants (IDLE..GAP), default `DW`/`GW`/`CW`.
- Sub-module `audio_gate_counter`: `cnt`/`phase` logic with `advance` strobe and `period` input, output `mute`.
- The FSM, capture register and drop counter stay in the top.

## Test plan
- Reset then `enable`=1, flags high, `left_in`=32'h1234_5678 → LATCH, then one-cycle `read_audio_in`=`write_audio_out`=1 two cycles later, `left_out`=32'h1234_5678, `level`=16'h1234.
- `gate_period`=3, 12 samples → outputs pass, pass, pass, zero×3, pass×3, zero×3. `cap_data` non-zero for all 12.
- `gate_period` changed 10→2 while `cnt`=7 → next XFER toggles phase and `cnt`=0, with no long run.
- `cap_ready`=0 for 300 samples → `cap_valid`=1, `cap_data`= first sample, `drop_cnt` saturates at 255. `cap_ready` pulse during an XFER loads the new word with no drop.
- `enable` dropped in LATCH → XFER and GAP still occur, then IDLE with handshakes held 0 while flags stay high.
- `resetn` asserted during XFER → pulses and outputs 0 asynchronously. After release, state is IDLE and `drop_cnt`=0.

Source files
------------

// File: rtl/audio_seq_pkg.sv
// Shared types and default widths for the audio sample sequencer slice.
package audio_seq_pkg;

  localparam int DW_DEFAULT = 32;
  localparam int GW_DEFAULT = 17;
  localparam int CW_DEFAULT = 8;
  localparam int CAP_W      = 16;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WAIT  = 3'd1,
    ST_LATCH = 3'd2,
    ST_XFER  = 3'd3,
    ST_GAP   = 3'd4
  } seq_state_t;

endpackage

// File: rtl/audio_sample_sequencer_if.sv
// Codec FIFO handshake plus the capture valid/ready stream, seen from the sequencer (master)
// and from the codec/consumer side (slave).
interface audio_sample_sequencer_if
  import audio_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT
);

  logic             audio_in_available;
  logic             audio_out_allowed;
  logic [DW-1:0]    left_in;
  logic [DW-1:0]    right_in;
  logic             read_audio_in;
  logic             write_audio_out;
  logic [DW-1:0]    left_out;
  logic [DW-1:0]    right_out;
  logic             cap_valid;
  logic             cap_ready;
  logic [CAP_W-1:0] cap_data;

  modport master (
    input  audio_in_available, audio_out_allowed, left_in, right_in, cap_ready,
    output read_audio_in, write_audio_out, left_out, right_out, cap_valid, cap_data
  );

  modport slave (
    output audio_in_available, audio_out_allowed, left_in, right_in, cap_ready,
    input  read_audio_in, write_audio_out, left_out, right_out, cap_valid, cap_data
  );

endinterface

// File: rtl/audio_gate_counter.sv
// Chopper gate: counts transferred samples and flips the mute phase every `period` samples.
module audio_gate_counter
  import audio_seq_pkg::*;
#(
  parameter int GW = GW_DEFAULT
) (
  input  logic          CLOCK_50,
  input  logic          resetn,
  input  logic          advance,
  input  logic [GW-1:0] period,
  output logic          mute
);

  localparam logic [GW-1:0] ONE = GW'(1);

  logic [GW-1:0] cnt_reg, cnt_next;
  logic          phase_reg, phase_next;

  // >= rather than == so shrinking the period mid-run wraps at once instead of after 2^GW.
  always_comb begin
    cnt_next   = cnt_reg;
    phase_next = phase_reg;
    if (advance) begin
      if (period == '0) begin
        cnt_next   = '0;
        phase_next = 1'b0;
      end else if (cnt_reg >= period - ONE) begin
        cnt_next   = '0;
        phase_next = ~phase_reg;
      end else begin
        cnt_next = cnt_reg + ONE;
      end
    end
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cnt_reg   <= '0;
      phase_reg <= 1'b0;
    end else begin
      cnt_reg   <= cnt_next;
      phase_reg <= phase_next;
    end
  end

  assign mute = phase_reg;

endmodule

// File: rtl/audio_sample_sequencer.sv
// Moves one stereo sample per pass from ADC FIFO to DAC FIFO, applying the chopper gate,
// offering a 16-bit left-channel capture word and holding the LED level.
module audio_sample_sequencer
  import audio_seq_pkg::*;
#(
  parameter int DW = DW_DEFAULT,
  parameter int GW = GW_DEFAULT,
  parameter int CW = CW_DEFAULT
) (
  input  logic                     CLOCK_50,
  input  logic                     resetn,
  input  logic                     enable,
  input  logic [GW-1:0]            gate_period,
  audio_sample_sequencer_if.master bus,
  output logic [CW-1:0]            drop_cnt,
  output logic [CAP_W-1:0]         level
);

  seq_state_t       state_reg, state_next;
  logic             pulse_reg, pulse_next;
  logic             latch_en, xfer_en;
  logic             mute;
  logic [CAP_W-1:0] cap_src_reg;
  logic [CAP_W-1:0] cap_data_reg;
  logic             cap_valid_reg;
  logic [CW-1:0]    drop_reg;
  logic [CAP_W-1:0] level_reg;
  logic [DW-1:0]    chan_in  [2];
  logic [DW-1:0]    chan_out [2];

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_reg <= ST_IDLE;
      pulse_reg <= 1'b0;
    end else begin
      state_reg <= state_next;
      pulse_reg <= pulse_next;
    end
  end

  always_comb begin
    state_next = state_reg;
    latch_en   = 1'b0;
    xfer_en    = 1'b0;
    case (state_reg)
      ST_IDLE:  if (enable) state_next = ST_WAIT;
      ST_WAIT: begin
        if (!enable)
          state_next = ST_IDLE;
        else if (bus.audio_in_available && bus.audio_out_allowed)
          state_next = ST_LATCH;
      end
      ST_LATCH: begin
        latch_en   = 1'b1;
        state_next = ST_XFER;
      end
      ST_XFER: begin
        xfer_en    = 1'b1;
        state_next = ST_GAP;
      end
      ST_GAP:   state_next = enable ? ST_WAIT : ST_IDLE;
      default:  state_next = ST_IDLE;
    endcase
    // Read and write share one flop so a pop is never seen without its push.
    pulse_next = (state_next == ST_XFER);
  end

  audio_gate_counter #(.GW(GW)) u_gate (
    .CLOCK_50 (CLOCK_50),
    .resetn   (resetn),
    .advance  (xfer_en),
    .period   (gate_period),
    .mute     (mute)
  );

  assign chan_in[0] = bus.left_in;
  assign chan_in[1] = bus.right_in;

  genvar gi;
  generate
    for (gi = 0; gi < 2; gi++) begin : g_chan
      logic [DW-1:0] out_reg;
      always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn)
          out_reg <= '0;
        else if (latch_en)
          out_reg <= mute ? '0 : chan_in[gi];
      end
      assign chan_out[gi] = out_reg;
    end
  endgenerate

  // Capture slot: a consumer handshake during XFER frees the slot for the new word.
  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      cap_src_reg   <= '0;
      cap_data_reg  <= '0;
      cap_valid_reg <= 1'b0;
      drop_reg      <= '0;
      level_reg     <= '0;
    end else begin
      if (latch_en)
        cap_src_reg <= bus.left_in[DW-1 -: CAP_W];
      if (xfer_en) begin
        level_reg <= chan_out[0][DW-1 -: CAP_W];
        if (!cap_valid_reg || bus.cap_ready) begin
          cap_data_reg  <= cap_src_reg;
          cap_valid_reg <= 1'b1;
        end else if (drop_reg != '1) begin
          drop_reg <= drop_reg + CW'(1);
        end
      end else if (cap_valid_reg && bus.cap_ready) begin
        cap_valid_reg <= 1'b0;
      end
    end
  end

  assign bus.read_audio_in   = pulse_reg;
  assign bus.write_audio_out = pulse_reg;
  assign bus.left_out        = chan_out[0];
  assign bus.right_out       = chan_out[1];
  assign bus.cap_valid       = cap_valid_reg;
  assign bus.cap_data        = cap_data_reg;
  assign drop_cnt            = drop_reg;
  assign level               = level_reg;

endmodule

// File: tb/tb_audio_sample_sequencer.sv
// Self-checking bench for audio_sample_sequencer: gate table, latency, capture drops, enable and reset corners.
module tb_audio_sample_sequencer;
  import audio_seq_pkg::*;

  localparam int DW = 32;
  localparam int GW = 17;
  localparam int CW = 8;

  logic          CLOCK_50    = 1'b0;
  logic          resetn      = 1'b0;
  logic          enable      = 1'b0;
  logic [GW-1:0] gate_period = '0;
  logic [CW-1:0] drop_cnt;
  logic [15:0]   level;

  audio_sample_sequencer_if #(.DW(DW)) bus ();

  audio_sample_sequencer #(.DW(DW), .GW(GW), .CW(CW)) dut (
    .CLOCK_50    (CLOCK_50),
    .resetn      (resetn),
    .enable      (enable),
    .gate_period (gate_period),
    .bus         (bus),
    .drop_cnt    (drop_cnt),
    .level       (level)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state, advanced once per transferred sample.
  int          m_cnt   = 0;
  bit          m_phase = 0;
  bit          m_valid = 0;
  logic [15:0] m_data  = '0;
  int          m_drop  = 0;
  logic [15:0] m_level = '0;

  typedef struct {
    logic [31:0] l;
    logic [31:0] r;
    bit          muted;
  } gate_vec_t;

  gate_vec_t   tbl [12];
  logic [31:0] el, er, got_l, got_r;
  logic [11:0] mute_mask = 12'b111000111000;
  logic [3:0]  chg_mask  = 4'b0110;
  bit          seen;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic void model_reset();
    m_cnt = 0; m_phase = 0; m_valid = 0; m_data = '0; m_drop = 0; m_level = '0;
  endfunction

  function automatic void model_xfer(input logic [31:0] l, input logic [31:0] r, input bit rdy,
                                     input int period, output logic [31:0] ol, output logic [31:0] orr);
    ol = m_phase ? 32'h0 : l;
    orr = m_phase ? 32'h0 : r;
    m_level = ol[31:16];
    if (period == 0) begin
      m_cnt = 0; m_phase = 0;
    end else if (m_cnt >= period - 1) begin
      m_cnt = 0; m_phase = !m_phase;
    end else begin
      m_cnt++;
    end
    if (!m_valid || rdy) begin
      m_valid = 1; m_data = l[31:16];
    end else if (m_drop < 255) begin
      m_drop++;
    end
  endfunction

  // One sample through the FIFO handshake; returns at the GAP-cycle negedge with flags low.
  task automatic run_sample(input logic [31:0] l, input logic [31:0] r, input bit rdy,
                            input bit rdy_on_xfer, output logic [31:0] ol, output logic [31:0] orr);
    logic [31:0] xl, xr;
    bit hit = 0;
    bus.left_in = l;
    bus.right_in = r;
    bus.cap_ready = rdy && !rdy_on_xfer;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed = 1'b1;
    ol = '0; orr = '0;
    for (int c = 0; c < 20 && !hit; c++) begin
      @(negedge CLOCK_50);
      if (bus.write_audio_out === 1'b1) hit = 1;
    end
    if (!hit) begin
      n_checks++; n_fail++;
      $display("FAIL xfer_timeout: got no write pulse, expected one within 20 cycles");
      bus.audio_in_available = 1'b0;
      bus.audio_out_allowed = 1'b0;
      return;
    end
    if (rdy_on_xfer) bus.cap_ready = 1'b1;
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed = 1'b0;
    model_xfer(l, r, bus.cap_ready, int'(gate_period), xl, xr);
    ol = bus.left_out; orr = bus.right_out;
    check("read_pulse", bus.read_audio_in, 1);
    check("left_out", bus.left_out, xl);
    check("right_out", bus.right_out, xr);
    @(negedge CLOCK_50);
    if (rdy_on_xfer) bus.cap_ready = 1'b0;
    check("write_width", bus.write_audio_out, 0);
    check("read_width", bus.read_audio_in, 0);
    check("level", level, m_level);
    check("cap_valid", bus.cap_valid, m_valid);
    check("cap_data", bus.cap_data, m_data);
    check("drop_cnt", drop_cnt, m_drop);
    $display("xfer in=%h/%h out=%h/%h cap_v=%0b cap=%h drop=%0d",
             l, r, ol, orr, bus.cap_valid, bus.cap_data, drop_cnt);
  endtask

  task automatic drain();
    bus.cap_ready = 1'b1;
    repeat (2) @(negedge CLOCK_50);
    m_valid = 0;
    check("drain_valid", bus.cap_valid, 0);
  endtask

  initial begin
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed  = 1'b0;
    bus.left_in  = '0;
    bus.right_in = '0;
    bus.cap_ready = 1'b0;
    for (int i = 0; i < 12; i++) begin
      tbl[i].l = {16'(16'hA100 + i), 16'(16'h0F00 + i)};
      tbl[i].r = {16'(16'h3300 + i), 16'h0055};
      tbl[i].muted = mute_mask[i];
    end

    // Reset state
    repeat (3) @(negedge CLOCK_50);
    check("rst_write", bus.write_audio_out, 0);
    check("rst_read", bus.read_audio_in, 0);
    check("rst_left_out", bus.left_out, 0);
    check("rst_cap_valid", bus.cap_valid, 0);
    check("rst_drop", drop_cnt, 0);
    check("rst_level", level, 0);
    resetn = 1'b1;
    @(negedge CLOCK_50);
    check("idle_write", bus.write_audio_out, 0);

    // First sample latency: flags in WAIT at n, pulse at n+2
    enable = 1'b1;
    @(negedge CLOCK_50);
    bus.left_in = 32'h1234_5678;
    bus.right_in = 32'h9ABC_DEF0;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed = 1'b1;
    check("lat_n_write", bus.write_audio_out, 0);
    @(negedge CLOCK_50);
    check("lat_n1_write", bus.write_audio_out, 0);
    @(negedge CLOCK_50);
    check("lat_n2_write", bus.write_audio_out, 1);
    check("lat_n2_read", bus.read_audio_in, 1);
    check("lat_left_out", bus.left_out, 32'h1234_5678);
    check("lat_right_out", bus.right_out, 32'h9ABC_DEF0);
    model_xfer(32'h1234_5678, 32'h9ABC_DEF0, bus.cap_ready, 0, el, er);
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed = 1'b0;
    @(negedge CLOCK_50);
    check("lat_n3_write", bus.write_audio_out, 0);
    check("lat_level", level, 16'h1234);
    check("lat_cap_valid", bus.cap_valid, 1);
    check("lat_cap_data", bus.cap_data, 16'h1234);

    // Gate period 3 over 12 samples
    gate_period = 17'd3;
    for (int i = 0; i < 12; i++) begin
      run_sample(tbl[i].l, tbl[i].r, 1'b1, 1'b0, got_l, got_r);
      check("gate_tbl_left", got_l, tbl[i].muted ? 32'h0 : tbl[i].l);
      check("gate_tbl_right", got_r, tbl[i].muted ? 32'h0 : tbl[i].r);
      check("gate_tbl_cap_nz", bus.cap_data != 16'h0, 1);
    end

    // Period shrinks 10 -> 2 with the counter at 7
    gate_period = 17'd10;
    for (int i = 0; i < 7; i++)
      run_sample({16'(16'h4000 + i), 16'h1}, 32'h2, 1'b1, 1'b0, got_l, got_r);
    gate_period = 17'd2;
    for (int i = 0; i < 4; i++) begin
      run_sample({16'(16'h4100 + i), 16'h1}, 32'h3, 1'b1, 1'b0, got_l, got_r);
      check("shrink_left", got_l, chg_mask[i] ? 32'h0 : {16'(16'h4100 + i), 16'h1});
    end

    // Random traffic against the model
    for (int i = 0; i < 40; i++) begin
      if ($urandom_range(0, 3) == 0) gate_period = GW'($urandom_range(0, 5));
      run_sample($urandom, $urandom, 1'($urandom_range(0, 1)), 1'b0, got_l, got_r);
    end

    // Consumer stalled for 300 samples: first word held, drops saturate
    gate_period = '0;
    drain();
    for (int i = 0; i < 300; i++)
      run_sample({16'(16'h5000 + i), 16'h0}, 32'h7, 1'b0, 1'b0, got_l, got_r);
    check("sat_drop", drop_cnt, 8'd255);
    check("sat_cap_data", bus.cap_data, 16'h5000);
    check("sat_cap_valid", bus.cap_valid, 1);

    // Ready only during XFER: new word loads without a drop
    run_sample(32'hBEEF_0000, 32'h8, 1'b1, 1'b1, got_l, got_r);
    check("xfer_rdy_data", bus.cap_data, 16'hBEEF);
    check("xfer_rdy_drop", drop_cnt, 8'd255);

    // Enable dropped in LATCH: sample completes, then IDLE with flags still high
    bus.left_in = 32'h7777_1111;
    bus.right_in = 32'h2222_3333;
    bus.audio_in_available = 1'b1;
    bus.audio_out_allowed = 1'b1;
    @(negedge CLOCK_50);
    check("en_wait_write", bus.write_audio_out, 0);
    @(negedge CLOCK_50);
    enable = 1'b0;
    @(negedge CLOCK_50);
    check("en_xfer_write", bus.write_audio_out, 1);
    model_xfer(32'h7777_1111, 32'h2222_3333, bus.cap_ready, int'(gate_period), el, er);
    check("en_xfer_left", bus.left_out, el);
    @(negedge CLOCK_50);
    check("en_gap_write", bus.write_audio_out, 0);
    check("en_gap_level", level, m_level);
    for (int i = 0; i < 5; i++) begin
      @(negedge CLOCK_50);
      check("en_idle_write", bus.write_audio_out, 0);
      check("en_idle_read", bus.read_audio_in, 0);
    end

    // Async reset during XFER
    enable = 1'b1;
    seen = 0;
    for (int c = 0; c < 20 && !seen; c++) begin
      @(negedge CLOCK_50);
      if (bus.write_audio_out === 1'b1) seen = 1;
    end
    check("rst_xfer_reached", seen, 1);
    resetn = 1'b0;
    #1;
    check("arst_write", bus.write_audio_out, 0);
    check("arst_read", bus.read_audio_in, 0);
    check("arst_left_out", bus.left_out, 0);
    check("arst_right_out", bus.right_out, 0);
    check("arst_level", level, 0);
    check("arst_cap_valid", bus.cap_valid, 0);
    check("arst_drop", drop_cnt, 0);
    enable = 1'b0;
    model_reset();
    @(negedge CLOCK_50);
    resetn = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge CLOCK_50);
      check("post_rst_idle_write", bus.write_audio_out, 0);
    end
    check("post_rst_drop", drop_cnt, 0);
    bus.audio_in_available = 1'b0;
    bus.audio_out_allowed = 1'b0;
    enable = 1'b1;
    run_sample(32'hCAFE_F00D, 32'h0BAD_BEEF, 1'b0, 1'b0, got_l, got_r);
    check("post_rst_left", got_l, 32'hCAFE_F00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
